wrr_stream_arbiter: RTL and testbench
=====================================

# wrr_stream_arbiter

Weighted round-robin arbiter for N valid/ready streams onto one output stream, with per-input burst quotas set by a runtime weight vector. It sits in front of a shared downstream resource, such as a memory port or an interconnect slave. Each requester gets up to `weight` back-to-back transfers per turn before ownership rotates. The request-to-output path is combinational, and arbitration state is registered. The output obeys AXI valid/ready stability.

## Interface
- `NumIn`, 4: number of input streams, ≥1, any value (not restricted to powers of two).
- `DataWidth`, 32: payload width.
- `WeightWidth`, 4: width of each per-input weight.
- `IdxWidth`, derived: `NumIn>1 ? $clog2(NumIn) : 1`.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `flush_i`  in  1  synchronous clear of arbitration state.
- `weight_i`  in  NumIn×WeightWidth  burst quota per input; 0 is treated as 1.
- `req_i`  in  NumIn  input valid.
- `gnt_o`  out  NumIn  input ready (one-hot or zero).
- `data_i`  in  NumIn×DataWidth  input payloads.
- `req_o`  out  1  output valid.
- `gnt_i`  in  1  output ready.
- `data_o`  out  DataWidth  selected payload.
- `idx_o`  out  IdxWidth  index of the selected input.

## Operation
- **State registers**
  - `ptr_q` (IdxWidth): current owner and search start.
  - `cnt_q` (WeightWidth): transfers already granted to `ptr_q` in this turn.
  - `lock_q` (1): output is valid but not yet accepted.
- **Selection (combinational)**
  - If `lock_q`, `sel = ptr_q`.
  - Else if `req_i[ptr_q]`, `sel = ptr_q`.
  - Else `sel` is the first set `req_i` bit scanning `ptr_q+1 … ptr_q+NumIn-1` cyclically, with wrap at `NumIn-1 → 0`.
- **Outputs**
  - `req_o = |req_i`.
  - `idx_o = sel`.
  - `data_o = data_i[sel]`.
  - `gnt_o = req_o & gnt_i ? onehot(sel) : '0`.
- **Effective weight:** `w = (weight_i[sel]==0) ? 1 : weight_i[sel]`.
- **On handshake (`req_o & gnt_i`):**
  - `base = (sel==ptr_q) ? cnt_q : 0`.
  - `nxt = base+1`, computed at WeightWidth+1 bits so there is no overflow at max weight.
  - If `nxt >= w`: `ptr_q <= (sel==NumIn-1) ? 0 : sel+1` and `cnt_q <= 0`. The turn ends.
  - Else: `ptr_q <= sel` and `cnt_q <= nxt`.
  - `lock_q <= 0`.
- **On stall (`req_o & !gnt_i`):**
  - `lock_q <= 1` and `ptr_q <= sel`.
  - `cnt_q <= (sel==ptr_q) ? cnt_q : 0`.
- **Idle (`!req_o`):** state holds.
- **Owner drops `req_i` mid-turn** (legal only when unlocked): its remaining quota is forfeited. The next requester starts a fresh turn with `base = 0`.
- **Weight changes** take effect at the next handshake comparison. If `cnt_q` already meets or exceeds the new weight, the next handshake ends the turn.
- **`flush_i`:** `ptr_q <= 0`, `cnt_q <= 0`, `lock_q <= 0`. It overrides any handshake update in the same cycle. It does not gate the combinational outputs.
- **`rst_i`:** same state clear as `flush_i`. While `rst_i` is high, `req_o`, `gnt_o`, `idx_o` and `data_o` are forced to 0.
- **Assertions (simulation)**
  - While `lock_q`: `req_i[ptr_q]` stays high and `data_i[ptr_q]` is stable.
  - `gnt_o` is one-hot or zero.
  - `gnt_o != 0` implies `req_o & gnt_i`.

## Timing
- Zero-cycle latency: `req_i → req_o/idx_o/data_o` and `gnt_i → gnt_o` are combinational in the same cycle.
- Arbitration state updates on the rising `clk_i` edge after the handshake or stall cycle.
- Reset values: `ptr_q = 0`, `cnt_q = 0`, `lock_q = 0`. All outputs are 0 while `rst_i` is high.
- After `rst_i` falls, the first cycle arbitrates from `ptr_q = 0`.
- Rotation costs no bubble: the cycle after a turn-ending handshake can grant the next input.
- Sustained throughput with `gnt_i = 1` is one transfer per cycle.

## Test plan
1. `NumIn=4`, weights {1,2,3,4}, all `req_i=1`, `gnt_i=1` → `idx_o` sequence 0,1,1,2,2,2,3,3,3,3, repeating. Over 1000 cycles the shares are 10/20/30/40% ±1 transfer.
2. Weights {0,0,0,0}, all requesting → sequence 0,1,2,3 repeating, so weight 0 behaves as 1.
3. Backpressure: only `req_i[2]` set, `gnt_i=0` for 5 cycles, then `req_i[3]` rises → `idx_o=2` and `data_o` stable throughout. Input 2 is granted at the first `gnt_i=1`, and input 3 is served in the next cycle.
4. Owner drop: all weights 3, `req_i[1]` served once then deasserted → the next grant goes to input 2 with `cnt_q=1` after its first transfer, and input 2 receives 3 consecutive grants.
5. Mid-turn clear: reach `ptr_q=2`, `cnt_q=1`, then pulse `rst_i` for 1 cycle with `flush_i=0` → outputs are 0 during reset and `idx_o=0` the following cycle. Repeat with `flush_i` instead, asserted in a handshake cycle → flush wins, and the next `idx_o` is 0.
6. `NumIn=3`, weights {1,1,1}, `WeightWidth=4`, and weight 15 on input 0 → wrap sequence 0,1,2,0. With weight 15, input 0 receives exactly 15 grants with no counter overflow.

Source files
------------

// File: rtl/wrr_stream_arbiter.sv
// rtl/wrr_stream_arbiter.sv - weighted round-robin arbiter merging N valid/ready streams onto one
module wrr_stream_arbiter #(
    parameter int  NumIn       = 4,
    parameter int  DataWidth   = 32,
    parameter int  WeightWidth = 4,
    localparam int IdxWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NumIn*WeightWidth-1:0] weight_i,
    input  logic [NumIn-1:0]             req_i,
    output logic [NumIn-1:0]             gnt_o,
    input  logic [NumIn*DataWidth-1:0]   data_i,
    output logic                         req_o,
    input  logic                         gnt_i,
    output logic [DataWidth-1:0]         data_o,
    output logic [IdxWidth-1:0]          idx_o
);

    logic [IdxWidth-1:0]    ptr_q;
    logic [WeightWidth-1:0] cnt_q;
    logic                   lock_q;

    logic [DataWidth-1:0]   data_arr   [NumIn];
    logic [WeightWidth-1:0] weight_arr [NumIn];

    for (genvar i = 0; i < NumIn; i++) begin : g_lane
        assign data_arr[i]   = data_i[i*DataWidth +: DataWidth];
        assign weight_arr[i] = weight_i[i*WeightWidth +: WeightWidth];
    end

    logic                   any_req;
    logic                   hs;
    logic                   found;
    logic [IdxWidth-1:0]    sel;
    logic [IdxWidth-1:0]    sel_inc;
    logic [WeightWidth-1:0] w_raw;
    logic [WeightWidth-1:0] base;
    logic [WeightWidth:0]   w_eff;
    logic [WeightWidth:0]   nxt;

    assign any_req = |req_i;
    assign hs      = any_req & gnt_i;

    // A locked or still-requesting owner keeps the output; otherwise scan cyclically past it.
    always_comb begin
        int j;
        j     = 0;
        sel   = ptr_q;
        found = 1'b0;
        if (!lock_q && !req_i[ptr_q]) begin
            for (int k = 1; k < NumIn; k++) begin
                j = int'(ptr_q) + k;
                if (j >= NumIn) j = j - NumIn;
                if (!found && req_i[IdxWidth'(j)]) begin
                    sel   = IdxWidth'(j);
                    found = 1'b1;
                end
            end
        end
    end

    assign sel_inc = (sel == IdxWidth'(NumIn - 1)) ? '0 : sel + IdxWidth'(1);
    assign w_raw   = weight_arr[sel];
    assign w_eff   = (w_raw == '0) ? (WeightWidth+1)'(1) : {1'b0, w_raw};
    assign base    = (sel == ptr_q) ? cnt_q : '0;
    // One extra bit so a full-scale weight cannot wrap the count.
    assign nxt     = {1'b0, base} + (WeightWidth+1)'(1);

    always_comb begin
        req_o  = 1'b0;
        gnt_o  = '0;
        idx_o  = '0;
        data_o = '0;
        if (!rst_i) begin
            req_o  = any_req;
            idx_o  = sel;
            data_o = data_arr[sel];
            if (hs) gnt_o[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else if (hs) begin
            lock_q <= 1'b0;
            if (nxt >= w_eff) begin
                ptr_q <= sel_inc;
                cnt_q <= '0;
            end else begin
                ptr_q <= sel;
                cnt_q <= nxt[WeightWidth-1:0];
            end
        end else if (any_req) begin
            lock_q <= 1'b1;
            ptr_q  <= sel;
            if (sel != ptr_q) cnt_q <= '0;
        end
    end

    a_lock_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        lock_q |-> (req_i[ptr_q] && data_o == $past(data_o)));
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(gnt_o));
    a_gnt_hs: assert property (@(posedge clk_i) disable iff (rst_i)
        (gnt_o != '0) |-> (req_o && gnt_i));

endmodule

// File: tb/tb_wrr_stream_arbiter.sv
// tb/tb_wrr_stream_arbiter.sv - self-checking bench for wrr_stream_arbiter
module tb_wrr_stream_arbiter;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush, gnt_i, req_o;
    logic [15:0]  weight;
    logic [3:0]   req, gnt_o;
    logic [127:0] data;
    logic [31:0]  data_o;
    logic [1:0]   idx_o;

    logic         rst3, flush3, gnt3_i, req3_o;
    logic [11:0]  weight3;
    logic [2:0]   req3, gnt3_o;
    logic [95:0]  data3;
    logic [31:0]  data3_o;
    logic [1:0]   idx3_o;

    wrr_stream_arbiter #(.NumIn(4), .DataWidth(32), .WeightWidth(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .weight_i(weight),
        .req_i(req), .gnt_o(gnt_o), .data_i(data), .req_o(req_o),
        .gnt_i(gnt_i), .data_o(data_o), .idx_o(idx_o)
    );

    wrr_stream_arbiter #(.NumIn(3), .DataWidth(32), .WeightWidth(4)) dut3 (
        .clk_i(clk), .rst_i(rst3), .flush_i(flush3), .weight_i(weight3),
        .req_i(req3), .gnt_o(gnt3_o), .data_i(data3), .req_o(req3_o),
        .gnt_i(gnt3_i), .data_o(data3_o), .idx_o(idx3_o)
    );

    int checks = 0;
    int passed = 0;

    // Reference: owner index, grants used in the current turn, and whether a stalled offer is pending.
    int m_ptr = 0;
    int m_cnt = 0;
    bit m_lock = 1'b0;

    function automatic int m_sel();
        int j;
        if (m_lock) return m_ptr;
        for (int i = 0; i < 4; i++) begin
            j = (m_ptr + i) % 4;
            if (req[j]) return j;
        end
        return m_ptr;
    endfunction

    task automatic model_clock();
        int s, w, used;
        s = m_sel();
        if (rst || flush) begin
            m_ptr = 0; m_cnt = 0; m_lock = 1'b0;
        end else if (req != 0 && gnt_i) begin
            w = int'(weight[s*4 +: 4]);
            if (w == 0) w = 1;
            used = (s == m_ptr) ? m_cnt : 0;
            if (used + 1 >= w) begin
                m_ptr = (s + 1) % 4; m_cnt = 0;
            end else begin
                m_ptr = s; m_cnt = used + 1;
            end
            m_lock = 1'b0;
        end else if (req != 0) begin
            if (s != m_ptr) m_cnt = 0;
            m_ptr = s;
            m_lock = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; req = '0; gnt_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; gnt_i = 1'b1; weight = 16'h4321;
        data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        checks++; if (req_o !== 1'b0) $display("FAIL reset_req_o got %0b want 0", req_o); else passed++;
        checks++; if (gnt_o !== 4'h0) $display("FAIL reset_gnt_o got %0h want 0", gnt_o); else passed++;
        checks++; if (idx_o !== 2'd0) $display("FAIL reset_idx_o got %0d want 0", idx_o); else passed++;
        checks++; if (data_o !== 32'h0) $display("FAIL reset_data_o got %0h want 0", data_o); else passed++;
        tick();
        tick();
    endtask

    task automatic test_weighted();
        int exp_seq[10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
        int share[4] = '{0, 0, 0, 0};
        int e;
        do_reset();
        weight = 16'h4321; req = 4'hF; gnt_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            e = exp_seq[c % 10];
            checks++; if (idx_o !== 2'(e)) $display("FAIL wrr_seq cycle %0d idx_o=%0d want %0d", c, idx_o, e); else passed++;
            checks++; if (gnt_o !== 4'(1 << e)) $display("FAIL wrr_gnt cycle %0d gnt_o=%0h want %0h", c, gnt_o, 1 << e); else passed++;
            tick();
        end
        for (int c = 0; c < 1000; c++) begin
            #1;
            share[idx_o]++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (share[i] < 100*(i+1) - 1 || share[i] > 100*(i+1) + 1)
                $display("FAIL wrr_share input %0d got %0d want %0d+-1", i, share[i], 100*(i+1));
            else passed++;
        end
    endtask

    task automatic test_zero_weight();
        do_reset();
        weight = 16'h0000; req = 4'hF; gnt_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (idx_o !== 2'(c % 4)) $display("FAIL zero_weight cycle %0d idx_o=%0d want %0d", c, idx_o, c % 4); else passed++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        weight = 16'h1111;
        data = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        req = 4'b0100; gnt_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) req = 4'b1100;
            #1;
            checks++; if (idx_o !== 2'd2 || req_o !== 1'b1 || gnt_o !== 4'h0)
                $display("FAIL bp_stall cycle %0d idx=%0d req_o=%0b gnt_o=%0h want 2/1/0", c, idx_o, req_o, gnt_o);
            else passed++;
            checks++; if (data_o !== 32'hCAFE_0002) $display("FAIL bp_data cycle %0d got %0h want cafe0002", c, data_o); else passed++;
            tick();
        end
        gnt_i = 1'b1;
        #1;
        checks++; if (idx_o !== 2'd2 || gnt_o !== 4'b0100) $display("FAIL bp_release idx=%0d gnt_o=%0h want 2/4", idx_o, gnt_o); else passed++;
        tick();
        req = 4'b1000;
        #1;
        checks++; if (idx_o !== 2'd3 || gnt_o !== 4'b1000 || data_o !== 32'hCAFE_0003)
            $display("FAIL bp_next idx=%0d gnt_o=%0h data=%0h want 3/8/cafe0003", idx_o, gnt_o, data_o);
        else passed++;
        tick();
    endtask

    task automatic test_owner_drop();
        do_reset();
        weight = 16'h3333; gnt_i = 1'b1; req = 4'b0110;
        #1;
        checks++; if (idx_o !== 2'd1) $display("FAIL drop_first idx=%0d want 1", idx_o); else passed++;
        tick();
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (idx_o !== 2'd2 || gnt_o !== 4'b0100) $display("FAIL drop_burst %0d idx=%0d gnt_o=%0h want 2/4", c, idx_o, gnt_o); else passed++;
            tick();
            if (c == 0) begin
                checks++; if (dut4.cnt_q !== 4'd1) $display("FAIL drop_cnt got %0d want 1", dut4.cnt_q); else passed++;
            end
        end
        req = 4'b0110;
        #1;
        checks++; if (idx_o !== 2'd1) $display("FAIL drop_rotate idx=%0d want 1", idx_o); else passed++;
        tick();
    endtask

    task automatic test_clear();
        do_reset();
        weight = 16'h3333; gnt_i = 1'b1; req = 4'b0100;
        tick();
        checks++; if (dut4.ptr_q !== 2'd2 || dut4.cnt_q !== 4'd1) $display("FAIL clear_setup ptr=%0d cnt=%0d want 2/1", dut4.ptr_q, dut4.cnt_q); else passed++;
        rst = 1'b1; req = 4'hF;
        #1;
        checks++; if (req_o !== 1'b0 || gnt_o !== 4'h0 || idx_o !== 2'd0 || data_o !== 32'h0)
            $display("FAIL clear_rst_outputs req_o=%0b gnt_o=%0h idx=%0d data=%0h want all 0", req_o, gnt_o, idx_o, data_o);
        else passed++;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (idx_o !== 2'd0) $display("FAIL clear_rst_after idx=%0d want 0", idx_o); else passed++;
        tick();
        do_reset();
        gnt_i = 1'b1; req = 4'b0100;
        tick();
        flush = 1'b1;
        #1;
        checks++; if (idx_o !== 2'd2 || gnt_o !== 4'b0100) $display("FAIL flush_not_gated idx=%0d gnt_o=%0h want 2/4", idx_o, gnt_o); else passed++;
        tick();
        flush = 1'b0; req = 4'hF;
        #1;
        checks++; if (idx_o !== 2'd0) $display("FAIL flush_after idx=%0d want 0", idx_o); else passed++;
        tick();
    endtask

    task automatic test_random();
        int s;
        bit any;
        logic [31:0] held;
        do_reset();
        weight = 16'h2131;
        for (int c = 0; c < 400; c++) begin
            held = data[m_ptr*32 +: 32];
            if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
            flush = ($urandom_range(0, 31) == 0);
            gnt_i = ($urandom_range(0, 3) != 0);
            req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) req = '0;
            data = {$urandom, $urandom, $urandom, $urandom};
            if (m_lock) begin
                req[m_ptr] = 1'b1;
                data[m_ptr*32 +: 32] = held;
            end
            #1;
            any = (req != 0);
            s = m_sel();
            checks++; if (req_o !== any) $display("FAIL rand_req_o cycle %0d got %0b want %0b", c, req_o, any); else passed++;
            checks++; if (gnt_o !== ((any && gnt_i) ? 4'(1 << s) : 4'h0))
                $display("FAIL rand_gnt_o cycle %0d got %0h sel %0d", c, gnt_o, s);
            else passed++;
            if (any) begin
                checks++; if (idx_o !== 2'(s) || data_o !== data[s*32 +: 32])
                    $display("FAIL rand_sel cycle %0d idx=%0d data=%0h want %0d/%0h", c, idx_o, data_o, s, data[s*32 +: 32]);
                else passed++;
            end
            tick();
        end
        flush = 1'b0; req = '0; gnt_i = 1'b0;
        tick();
    endtask

    task automatic test_wrap3();
        int e;
        rst3 = 1'b1; req3 = 3'b111; gnt3_i = 1'b1; weight3 = 12'h111;
        data3 = {32'hB2, 32'hB1, 32'hB0};
        tick();
        rst3 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            e = c % 3;
            checks++; if (idx3_o !== 2'(e) || gnt3_o !== 3'(1 << e) || data3_o !== 32'(32'hB0 + e))
                $display("FAIL wrap3 cycle %0d idx=%0d gnt=%0h data=%0h want %0d", c, idx3_o, gnt3_o, data3_o, e);
            else passed++;
            tick();
        end
        rst3 = 1'b1; weight3 = {4'd1, 4'd1, 4'd15};
        tick();
        rst3 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            #1;
            e = (c < 15) ? 0 : 1;
            checks++; if (idx3_o !== 2'(e)) $display("FAIL wrap3_w15 cycle %0d idx=%0d want %0d", c, idx3_o, e); else passed++;
            tick();
        end
        rst3 = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; gnt_i = 1'b0; req = '0; weight = '0; data = '0;
        rst3 = 1'b1; flush3 = 1'b0; gnt3_i = 1'b0; req3 = '0; weight3 = '0; data3 = '0;
        @(negedge clk);
        test_reset();
        test_weighted();
        test_zero_weight();
        test_backpressure();
        test_owner_drop();
        test_clear();
        test_random();
        test_wrap3();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
